dual_issue_ctrl: RTL and testbench

Decode-stage issue controller for the two-slot superscalar front end. It inspects the instruction pair held in the IF/ID register (slot 0 = older instruction A, slot 1 = younger instruction B). From that pair it generates that register's per-slot stall and flush controls, the fetch stall, and the per-slot issue enables into ID/EX. When the pair cannot issue together, it splits the pair over two cycles. It also applies redirect flushes and keeps issue statistics.

---
 rtl/dual_issue_ctrl_if.sv | 32 +++
 rtl/dual_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_dual_issue_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dual_issue_ctrl_if.sv
// Issue-controller bundle: IF/ID instruction pair and pipeline hazards in,
// stage stall/flush/issue controls and issue statistics out.
interface dual_issue_ctrl_if;
  logic [31:0] instrD_a;
  logic [31:0] instrD_b;
  logic        hazard_stall;
  logic        redirectE;
  logic        redirect_slotE;
  logic        StallF;
  logic        StallD_0;
  logic        StallD_1;
  logic        FlushD_0;
  logic        FlushD_1;
  logic        FlushE_1;
  logic        issue_0;
  logic        issue_1;
  logic        split_q;
  logic [31:0] pair_cnt;
  logic [31:0] split_cnt;

  modport master (
    output instrD_a, instrD_b, hazard_stall, redirectE, redirect_slotE,
    input  StallF, StallD_0, StallD_1, FlushD_0, FlushD_1, FlushE_1,
           issue_0, issue_1, split_q, pair_cnt, split_cnt
  );

  modport slave (
    input  instrD_a, instrD_b, hazard_stall, redirectE, redirect_slotE,
    output StallF, StallD_0, StallD_1, FlushD_0, FlushD_1, FlushE_1,
           issue_0, issue_1, split_q, pair_cnt, split_cnt
  );
endinterface

// File: rtl/dual_issue_ctrl.sv
// Decode-stage dual-issue controller: detects intra-pair conflicts, splits
// conflicting pairs over two cycles, applies redirects/stalls, counts issues.
module dual_issue_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  dual_issue_ctrl_if.slave   bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [0:0] PAIR  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [0:0]  state_q, state_d;
  logic [31:0] pair_cnt_q, pair_cnt_d;
  logic [31:0] split_cnt_q, split_cnt_d;

  logic [6:0] op_a, op_b;
  logic [4:0] rd_a, rs1_b, rs2_b;
  logic       a_wr, a_mem, a_ctl, b_rs1, b_rs2, b_mem;
  logic       raw, conflict;

  assign op_a  = bus.instrD_a[6:0];
  assign rd_a  = bus.instrD_a[11:7];
  assign op_b  = bus.instrD_b[6:0];
  assign rs1_b = bus.instrD_b[19:15];
  assign rs2_b = bus.instrD_b[24:20];

  always_comb begin
    a_wr  = 1'b0;
    a_mem = 1'b0;
    a_ctl = 1'b0;
    case (op_a)
      OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP: a_wr = 1'b1;
      OP_LOAD:                           begin a_wr = 1'b1; a_mem = 1'b1; end
      OP_JAL, OP_JALR:                   begin a_wr = 1'b1; a_ctl = 1'b1; end
      OP_STORE:                          a_mem = 1'b1;
      OP_BRANCH:                         a_ctl = 1'b1;
      default:                           ;
    endcase
  end

  always_comb begin
    b_rs1 = 1'b1;
    b_rs2 = 1'b0;
    b_mem = 1'b0;
    case (op_b)
      OP_LUI, OP_AUIPC, OP_JAL: b_rs1 = 1'b0;
      OP_BRANCH, OP_OP:         b_rs2 = 1'b1;
      OP_STORE:                 begin b_rs2 = 1'b1; b_mem = 1'b1; end
      OP_LOAD:                  b_mem = 1'b1;
      default:                  ;
    endcase
  end

  assign raw = a_wr && (rd_a != 5'd0) &&
               ((b_rs1 && (rs1_b == rd_a)) || (b_rs2 && (rs2_b == rd_a)));
  assign conflict = (bus.instrD_a != NOP) && (bus.instrD_b != NOP) &&
                    (raw || (a_mem && b_mem) || a_ctl);

  // Outputs stay low throughout reset so the front end sees no stray enables.
  always_comb begin
    bus.StallF   = 1'b0;
    bus.StallD_0 = 1'b0;
    bus.StallD_1 = 1'b0;
    bus.FlushD_0 = 1'b0;
    bus.FlushD_1 = 1'b0;
    bus.FlushE_1 = 1'b0;
    bus.issue_0  = 1'b0;
    bus.issue_1  = 1'b0;
    state_d      = state_q;
    pair_cnt_d   = pair_cnt_q;
    split_cnt_d  = split_cnt_q;
    if (rst_n) begin
      if (bus.redirectE) begin
        bus.FlushD_0 = 1'b1;
        bus.FlushD_1 = 1'b1;
        bus.FlushE_1 = ~bus.redirect_slotE;
        state_d      = PAIR;
      end else if (bus.hazard_stall) begin
        bus.StallF   = 1'b1;
        bus.StallD_0 = 1'b1;
        bus.StallD_1 = 1'b1;
      end else if (state_q == PAIR) begin
        if (!conflict) begin
          bus.issue_0 = 1'b1;
          bus.issue_1 = 1'b1;
          pair_cnt_d  = pair_cnt_q + 32'd1;
        end else begin
          bus.issue_0  = 1'b1;
          bus.StallF   = 1'b1;
          bus.StallD_1 = 1'b1;
          bus.FlushD_0 = 1'b1;
          state_d      = SPLIT;
          split_cnt_d  = split_cnt_q + 32'd1;
        end
      end else begin
        bus.issue_1 = 1'b1;
        state_d     = PAIR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PAIR;
      pair_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pair_cnt_q  <= pair_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign bus.split_q   = (state_q == SPLIT);
  assign bus.pair_cnt  = pair_cnt_q;
  assign bus.split_cnt = split_cnt_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed vector table, hand sequences for
// redirect/stall/reset corners, and randomized pairs against a rule model.
module tb_dual_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  dual_issue_ctrl_if bus ();

  dual_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference state
  bit          m_split;
  logic [31:0] m_pair, m_splitcnt;

  typedef struct {
    string       name;
    logic [31:0] a, b;
    bit          hz, rd, rs;
    logic [7:0]  ctrl;   // {StallF,StallD_0,StallD_1,FlushD_0,FlushD_1,FlushE_1,issue_0,issue_1}
    bit          split;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  function automatic logic [7:0] ctrl_now();
    return {bus.StallF, bus.StallD_0, bus.StallD_1, bus.FlushD_0, bus.FlushD_1,
            bus.FlushE_1, bus.issue_0, bus.issue_1};
  endfunction

  function automatic bit m_conflict(logic [31:0] a, logic [31:0] b);
    logic [6:0] oa, ob;
    bit wr, r1, r2;
    oa = a[6:0];
    ob = b[6:0];
    if (a == NOP || b == NOP) return 0;
    wr = oa inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33};
    r1 = !(ob inside {7'h37, 7'h17, 7'h6f});
    r2 = ob inside {7'h63, 7'h23, 7'h33};
    if (wr && a[11:7] != 0 && ((r1 && b[19:15] == a[11:7]) || (r2 && b[24:20] == a[11:7])))
      return 1;
    if ((oa inside {7'h03, 7'h23}) && (ob inside {7'h03, 7'h23})) return 1;
    return oa inside {7'h63, 7'h6f, 7'h67};
  endfunction

  function automatic logic [7:0] m_ctrl(logic [31:0] a, logic [31:0] b, bit hz, bit rd, bit rs);
    if (rd)       return {3'b000, 2'b11, !rs, 2'b00};
    if (hz)       return 8'b1110_0000;
    if (m_split)  return 8'b0000_0001;
    if (m_conflict(a, b)) return 8'b1011_0010;
    return 8'b0000_0011;
  endfunction

  // One cycle: drive at negedge, check 1ns later, then advance the model.
  task automatic step(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input bit hz, input bit rd, input bit rs);
    logic [7:0] e;
    @(negedge clk);
    bus.instrD_a = a;  bus.instrD_b = b;
    bus.hazard_stall = hz;  bus.redirectE = rd;  bus.redirect_slotE = rs;
    #1;
    e = m_ctrl(a, b, hz, rd, rs);
    chk({nm, ".ctrl"}, {24'd0, ctrl_now()}, {24'd0, e});
    chk({nm, ".split_q"}, {31'd0, bus.split_q}, {31'd0, m_split});
    chk({nm, ".pair_cnt"}, bus.pair_cnt, m_pair);
    chk({nm, ".split_cnt"}, bus.split_cnt, m_splitcnt);
    if (rd)            m_split = 0;
    else if (hz)       ;
    else if (m_split)  m_split = 0;
    else if (m_conflict(a, b)) begin m_split = 1; m_splitcnt++; end
    else               m_pair++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h73};
    logic [31:0] w;
    if ($urandom_range(0, 7) == 0) return NOP;
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    vecs[0] = '{"indep",     32'h00500093, 32'h00700113, 0, 0, 0, 8'b0000_0011, 0};
    vecs[1] = '{"raw_n",     32'h00500093, 32'h001081B3, 0, 0, 0, 8'b1011_0010, 0};
    vecs[2] = '{"raw_n1",    NOP,          32'h001081B3, 0, 0, 0, 8'b0000_0001, 1};
    vecs[3] = '{"x0_exempt", 32'h00100013, 32'h000001B3, 0, 0, 0, 8'b0000_0011, 0};
    vecs[4] = '{"nop_exempt",32'h00012083, NOP,          0, 0, 0, 8'b0000_0011, 0};
    vecs[5] = '{"struct",    32'h00012083, 32'h00532223, 0, 0, 0, 8'b1011_0010, 0};
    vecs[6] = '{"redir_s0",  NOP,          32'h00532223, 1, 1, 0, 8'b0001_1100, 1};
    vecs[7] = '{"ctl_split", 32'h00000463, 32'h00700113, 0, 0, 0, 8'b1011_0010, 0};
    vecs[8] = '{"redir_s1",  NOP,          32'h00700113, 0, 1, 1, 8'b0001_1000, 1};

    bus.instrD_a = NOP;  bus.instrD_b = NOP;
    bus.hazard_stall = 1'b1;  bus.redirectE = 1'b0;  bus.redirect_slotE = 1'b0;
    rst_n = 1'b0;
    m_split = 0;  m_pair = '0;  m_splitcnt = '0;
    #12;
    chk("reset.ctrl", {24'd0, ctrl_now()}, 32'd0);
    chk("reset.split_q", {31'd0, bus.split_q}, 32'd0);
    chk("reset.pair_cnt", bus.pair_cnt, 32'd0);
    chk("reset.split_cnt", bus.split_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].hz, vecs[i].rd, vecs[i].rs);
      chk({vecs[i].name, ".tbl_ctrl"}, {24'd0, ctrl_now()}, {24'd0, vecs[i].ctrl});
      chk({vecs[i].name, ".tbl_split"}, {31'd0, bus.split_q}, {31'd0, vecs[i].split});
    end
    // Counter values after the table: pairs from rows 0,3,4; splits from rows 1,5,7.
    step("tbl_tail", 32'h00500093, 32'h00700113, 0, 0, 0);
    chk("tbl.pair_cnt", bus.pair_cnt, 32'd3);
    chk("tbl.split_cnt", bus.split_cnt, 32'd3);

    // Load-use hold in SPLIT: three stalled cycles, B issues in the fourth.
    step("hold_n", 32'h00500093, 32'h001081B3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("hold_stall", NOP, 32'h001081B3, 1, 0, 0);
      chk("hold.split_q", {31'd0, bus.split_q}, 32'd1);
    end
    step("hold_issue", NOP, 32'h001081B3, 0, 0, 0);
    chk("hold.issue_1", {24'd0, ctrl_now()}, 32'h01);

    // Asynchronous reset mid-split.
    step("rst_n_pre", 32'h00500093, 32'h001081B3, 0, 0, 0);
    @(negedge clk);
    bus.hazard_stall = 1'b0;
    #2;
    chk("midrst.pre_split", {31'd0, bus.split_q}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.ctrl", {24'd0, ctrl_now()}, 32'd0);
    chk("midrst.split_q", {31'd0, bus.split_q}, 32'd0);
    chk("midrst.pair_cnt", bus.pair_cnt, 32'd0);
    chk("midrst.split_cnt", bus.split_cnt, 32'd0);
    m_split = 0;  m_pair = '0;  m_splitcnt = '0;
    bus.hazard_stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 32'h00500093, 32'h00700113, 0, 0, 0);
    chk("post_rst.ctrl", {24'd0, ctrl_now()}, 32'h03);

    for (int i = 0; i < 400; i++)
      step("rand", rand_instr(), rand_instr(), $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
